// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan byte decoder: pops bytes from the ps2_keyboard FIFO, tracks
// E0/F0 prefixes, filters typematic repeats and presents the held key.
// Optional build macro: KBD_SHIFT_EN (shift keys select uppercase letters).
module ps2_key_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  output logic             kbd_nextdata_n,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic             key_valid,
  output logic             key_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             press_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic [7:0]       key_code_q, key_code_d;
  logic [7:0]       key_ascii_q, key_ascii_d;
  logic             key_valid_q, key_valid_d;
  logic             key_ext_q, key_ext_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             press_pulse_q, press_pulse_d;
  logic             shift_l_q, shift_l_d;
  logic             shift_r_q, shift_r_d;
  logic             same_key;

  // Scan code to ASCII; extended codes are unmapped, 'up' selects uppercase letters
  function automatic logic [7:0] map_ascii(input logic [7:0] b, input logic ext,
                                           input logic up);
    logic [7:0] a;
    a = 8'h00;
    if (!ext) begin
      case (b)
        8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
        8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
        8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
        8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
        8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
        8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
        8'h35: a = "y";  8'h1A: a = "z";
        8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
        8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
        8'h3E: a = "8";  8'h46: a = "9";
        8'h29: a = 8'h20;
        default: a = 8'h00;
      endcase
    end
    if (up && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
    return a;
  endfunction

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      nextdata_n_q  <= 1'b1;
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      key_code_q    <= 8'h00;
      key_ascii_q   <= 8'h00;
      key_valid_q   <= 1'b0;
      key_ext_q     <= 1'b0;
      press_cnt_q   <= '0;
      press_pulse_q <= 1'b0;
      shift_l_q     <= 1'b0;
      shift_r_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      nextdata_n_q  <= nextdata_n_d;
      brk_q         <= brk_d;
      ext_q         <= ext_d;
      key_code_q    <= key_code_d;
      key_ascii_q   <= key_ascii_d;
      key_valid_q   <= key_valid_d;
      key_ext_q     <= key_ext_d;
      press_cnt_q   <= press_cnt_d;
      press_pulse_q <= press_pulse_d;
      shift_l_q     <= shift_l_d;
      shift_r_q     <= shift_r_d;
    end
  end

  assign same_key = key_valid_q && (kbd_data == key_code_q) && (ext_q == key_ext_q);

  // Handshake sequencing and byte decode on the accepting edge
  always_comb begin
    state_d       = state_q;
    brk_d         = brk_q;
    ext_d         = ext_q;
    key_code_d    = key_code_q;
    key_ascii_d   = key_ascii_q;
    key_valid_d   = key_valid_q;
    key_ext_d     = key_ext_q;
    press_cnt_d   = press_cnt_q;
    press_pulse_d = 1'b0;
    shift_l_d     = shift_l_q;
    shift_r_d     = shift_r_q;

    case (state_q)
      ST_IDLE: begin
        if (kbd_ready) begin
          state_d = ST_POP;
          if (kbd_data == 8'hF0) begin
            brk_d = 1'b1;
          end else if (kbd_data == 8'hE0) begin
            ext_d = 1'b1;
`ifdef KBD_SHIFT_EN
          end else if ((kbd_data == 8'h12) || (kbd_data == 8'h59)) begin
            if (kbd_data == 8'h12) shift_l_d = !brk_q;
            else                   shift_r_d = !brk_q;
            brk_d = 1'b0;
            ext_d = 1'b0;
`endif
          end else if (brk_q) begin
            if (same_key) key_valid_d = 1'b0;
            brk_d = 1'b0;
            ext_d = 1'b0;
          end else begin
            ext_d = 1'b0;
            if (!same_key) begin
              key_code_d    = kbd_data;
              key_ext_d     = ext_q;
              key_valid_d   = 1'b1;
              key_ascii_d   = map_ascii(kbd_data, ext_q, shift_l_q || shift_r_q);
              press_cnt_d   = press_cnt_q + CNT_W'(1);
              press_pulse_d = 1'b1;
            end
          end
        end
      end
      ST_POP:  state_d = ST_WAIT;
      ST_WAIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pop strobe is low exactly while the FSM sits in POP
    nextdata_n_d = (state_d != ST_POP);
  end

  assign kbd_nextdata_n = nextdata_n_q;
  assign key_code       = key_code_q;
  assign key_ascii      = key_ascii_q;
  assign key_valid      = key_valid_q;
  assign key_ext        = key_ext_q;
  assign press_cnt      = press_cnt_q;
  assign press_pulse    = press_pulse_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: vector table, corner sequences and
// randomized bytes against a held-key reference model.
module tb_ps2_key_decoder;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             resetn;
  logic [7:0]       kbd_data;
  logic             kbd_ready;
  logic             kbd_nextdata_n;
  logic [7:0]       key_code;
  logic [7:0]       key_ascii;
  logic             key_valid;
  logic             key_ext;
  logic [CNT_W-1:0] press_cnt;
  logic             press_pulse;

  ps2_key_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_nextdata_n(kbd_nextdata_n), .key_code(key_code), .key_ascii(key_ascii),
    .key_valid(key_valid), .key_ext(key_ext), .press_cnt(press_cnt),
    .press_pulse(press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int low_run = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pop strobe width and press pulse counting, sampled mid-cycle
  always @(negedge clk) begin
    if (press_pulse === 1'b1) pulses++;
    if (kbd_nextdata_n === 1'b0) low_run++;
    else if (low_run > 0) begin
      chk("pop_strobe_width", 32'(low_run), 32'd1);
      low_run = 0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] letter_codes [26];
  logic [7:0] digit_codes  [10];
  bit         m_brk, m_ext, m_valid, m_kext, m_shl, m_shr;
  logic [7:0] m_code, m_ascii;
  int         m_cnt, m_presses;

  function automatic logic [7:0] ref_map(input logic [7:0] b, input bit ext, input bit up);
    if (ext) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == b) return (up ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == b) return 8'h30 + 8'(i);
    if (b == 8'h29) return 8'h20;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_valid = 0; m_kext = 0; m_shl = 0; m_shr = 0;
    m_code = 0; m_ascii = 0; m_cnt = 0;
  endtask

  task automatic model_apply(input logic [7:0] b);
    bit same;
    same = m_valid && (b == m_code) && (m_ext == m_kext);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
`ifdef KBD_SHIFT_EN
    else if (b == 8'h12 || b == 8'h59) begin
      if (b == 8'h12) m_shl = !m_brk; else m_shr = !m_brk;
      m_brk = 0; m_ext = 0;
    end
`endif
    else if (m_brk) begin
      if (same) m_valid = 0;
      m_brk = 0; m_ext = 0;
    end else begin
      if (!same) begin
        m_code = b; m_kext = m_ext; m_valid = 1;
        m_ascii = ref_map(b, m_ext, m_shl || m_shr);
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_presses++;
      end
      m_ext = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(key_valid), 32'(m_valid));
    chk({tag, "_code"},  32'(key_code),  32'(m_code));
    chk({tag, "_ascii"}, 32'(key_ascii), 32'(m_ascii));
    chk({tag, "_ext"},   32'(key_ext),   32'(m_kext));
    chk({tag, "_cnt"},   32'(press_cnt), 32'(m_cnt));
  endtask

  // ---------------- FIFO-side driver ----------------
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    kbd_data = b;
    kbd_ready = 1'b1;
    @(negedge clk);
    while (kbd_nextdata_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("pop_timeout", 32'd1, 32'd0);
      kbd_ready = 1'b0;
      return;
    end
    @(posedge clk);
    #1 kbd_ready = 1'b0;
    model_apply(b);
  endtask

  task automatic do_reset();
    kbd_ready = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_nextdata_n", 32'(kbd_nextdata_n), 32'd1);
    chk("rst_outputs", {key_code, key_ascii, press_cnt, 5'd0, key_valid, key_ext, press_pulse}, 32'd0);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       v;
    logic [7:0] code;
    logic [7:0] ascii;
    logic       ext;
    logic [7:0] cnt;
  } vec_t;

  vec_t       tv [13];
  logic [7:0] pool [10];
  logic [7:0] stream [3];
  int         starts [3];
  int         p0, n;

  initial begin
    letter_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                     8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                     8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digit_codes  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    pool = '{8'h1C, 8'h32, 8'h16, 8'h75, 8'hF0, 8'hF0, 8'hE0, 8'h29, 8'h12, 8'h45};
    tv[0]  = '{8'h1C, 1, 8'h1C, 8'h61, 0, 8'd1};
    tv[1]  = '{8'hF0, 1, 8'h1C, 8'h61, 0, 8'd1};
    tv[2]  = '{8'h1C, 0, 8'h1C, 8'h61, 0, 8'd1};
    tv[3]  = '{8'h16, 1, 8'h16, 8'h31, 0, 8'd2};
    tv[4]  = '{8'h16, 1, 8'h16, 8'h31, 0, 8'd2};
    tv[5]  = '{8'h16, 1, 8'h16, 8'h31, 0, 8'd2};
    tv[6]  = '{8'hF0, 1, 8'h16, 8'h31, 0, 8'd2};
    tv[7]  = '{8'h16, 0, 8'h16, 8'h31, 0, 8'd2};
    tv[8]  = '{8'hE0, 0, 8'h16, 8'h31, 0, 8'd2};
    tv[9]  = '{8'h75, 1, 8'h75, 8'h00, 1, 8'd3};
    tv[10] = '{8'hE0, 1, 8'h75, 8'h00, 1, 8'd3};
    tv[11] = '{8'hF0, 1, 8'h75, 8'h00, 1, 8'd3};
    tv[12] = '{8'h75, 0, 8'h75, 8'h00, 1, 8'd3};

    kbd_data = 8'h00;
    kbd_ready = 1'b0;
    resetn = 1'b0;
    m_presses = 0;
    #12;
    do_reset();

    // Table: basic press/release, typematic, extended
    p0 = pulses;
    for (int i = 0; i < 13; i++) begin
      send(tv[i].b);
      chk($sformatf("tv%0d_valid", i), 32'(key_valid), 32'(tv[i].v));
      chk($sformatf("tv%0d_code", i),  32'(key_code),  32'(tv[i].code));
      chk($sformatf("tv%0d_ascii", i), 32'(key_ascii), 32'(tv[i].ascii));
      chk($sformatf("tv%0d_ext", i),   32'(key_ext),   32'(tv[i].ext));
      chk($sformatf("tv%0d_cnt", i),   32'(press_cnt), 32'(tv[i].cnt));
    end
    chk("tv_pulses", 32'(pulses - p0), 32'd3);
    send(8'h75);
    chk("plain75_ext", 32'(key_ext), 32'd0);
    chk("plain75_valid", 32'(key_valid), 32'd1);
    chk("plain75_cnt", 32'(press_cnt), 32'd4);

    // Streamed bytes with ready held: pop strobes three cycles apart
    stream = '{8'h32, 8'hF0, 8'h32};
    @(negedge clk);
    kbd_data = stream[0];
    kbd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      @(negedge clk);
      while (kbd_nextdata_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("stream_timeout", 32'd1, 32'd0);
      starts[i] = cyc;
      @(posedge clk);
      #1;
      model_apply(stream[i]);
      if (i < 2) kbd_data = stream[i+1];
      else kbd_ready = 1'b0;
    end
    chk("stream_gap0", 32'(starts[1] - starts[0]), 32'd3);
    chk("stream_gap1", 32'(starts[2] - starts[1]), 32'd3);
    check_model("stream");

    // Reset during POP after F0: strobe released at once, prefix lost
    @(negedge clk);
    kbd_data = 8'hF0;
    kbd_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (kbd_nextdata_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("midrst_in_pop", 32'(kbd_nextdata_n), 32'd0);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_nextdata_n", 32'(kbd_nextdata_n), 32'd1);
    chk("midrst_outputs", {key_code, key_ascii, press_cnt, 5'd0, key_valid, key_ext, press_pulse}, 32'd0);
    kbd_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    send(8'h1C);
    chk("postrst_make_valid", 32'(key_valid), 32'd1);
    chk("postrst_make_cnt", 32'(press_cnt), 32'd1);

    // Counter wrap over 256 alternating presses
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
    chk("wrap_cnt", 32'(press_cnt), 32'd0);
    chk("wrap_pulses", 32'(pulses - p0), 32'd256);

`ifdef KBD_SHIFT_EN
    do_reset();
    send(8'h12); send(8'h1C);
    chk("shift_upper", 32'(key_ascii), 32'h41);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    chk("shift_lower", 32'(key_ascii), 32'h61);
    chk("shift_cnt", 32'(press_cnt), 32'd2);
`endif

    // Randomized byte stream against the model
    do_reset();
    p0 = pulses;
    m_presses = 0;
    for (int i = 0; i < 200; i++) begin
      send(pool[$urandom_range(0, 9)]);
      check_model($sformatf("rnd%0d", i));
    end
    @(negedge clk);
    chk("rnd_pulses", 32'(pulses - p0), 32'(m_presses));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Consumes raw PS/2 Set-2 scan bytes from the ps2_keyboard FIFO (data/ready/nextdata_n handshake) and turns them into held-key state for the seg display stage.
- Pops one byte at a time.
- Tracks break (F0) and extended (E0) prefixes.
- Filters typematic repeats.
- Outputs current scan code, ASCII, and a press counter.

Parameters:
CNT_W, 8, width of press counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
kbd_data  input  8  FIFO head byte from ps2_keyboard
kbd_ready  input  1  FIFO non-empty
kbd_nextdata_n  output  1  active-low pop strobe to ps2_keyboard
key_code  output  8  scan code of currently/last held key
key_ascii  output  8  ASCII of key_code, 0x00 if unmapped
key_valid  output  1  high while a key is held
key_ext  output  1  held key was E0-prefixed
press_cnt  output  CNT_W  count of distinct key presses
press_pulse  output  1  one-cycle strobe on each counted press

Behaviour:
- Single clock; reset is asynchronous, active-low.
- Reset values: all outputs 0, except kbd_nextdata_n = 1. FSM goes to IDLE and prefix flags brk/ext are cleared.
- FSM has three states:
  - IDLE: if kbd_ready, sample kbd_data, decode on this edge, go to POP. Otherwise stay.
  - POP: kbd_nextdata_n = 0 for exactly this cycle, registered from state. Go to WAIT.
  - WAIT: kbd_nextdata_n = 1. Allows the FIFO to advance ready. Go to IDLE.
- Throughput is at most 1 byte per 3 cycles. Outputs change on the same edge the byte is accepted.
- Decode of an accepted byte b:
  - b = F0: set brk. No output change.
  - b = E0: set ext. No output change.
  - Otherwise, with brk = 1 (release):
    - If key_valid, b == key_code and ext == key_ext: key_valid <= 0.
    - Release of any other code is ignored.
    - Clear brk and ext.
  - Otherwise, with brk = 0 (make):
    - If key_valid, b == key_code and ext == key_ext: typematic repeat. No change except clearing ext.
    - Else new press: key_code <= b, key_ext <= ext, key_valid <= 1, key_ascii <= map(b, ext), press_cnt <= press_cnt + 1 (wraps), press_pulse <= 1 for one cycle. Clear ext.
- press_pulse defaults to 0 on every other cycle.
- A new press while another key is held replaces it. No rollover tracking.
- key_code and key_ascii hold their last values after release.
- map(b, ext) = 0x00 if ext = 1. Otherwise:
  - Letters, lowercase: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - 29 -> 0x20 (space).
  - All others -> 0x00.
- kbd_ready falling while in POP/WAIT is a don't-care. The FSM completes the sequence regardless.
- Reset asserted mid-sequence (POP/WAIT) aborts immediately: kbd_nextdata_n returns to 1 asynchronously and pending prefixes are lost.

Optional Feature:
KBD_SHIFT_EN
- Defined:
  - Make/break of 12 (L-shift) and 59 (R-shift) updates internal shift_l/shift_r flags only. These bytes do not change key_code/key_valid/press_cnt.
  - While either flag is set, letters map to uppercase (0x41-0x5A). Digits are unchanged.
  - The mapping is latched at press time.
- Not defined: 12/59 are ordinary keys with ASCII 0x00, counted as presses.

Test Plan:
- Bytes 1C, F0, 1C with ready held appropriately:
  - After 1C: key_code = 1C, key_ascii = 0x61, key_valid = 1, press_cnt = 1, press_pulse for 1 cycle.
  - After F0 1C: key_valid = 0, press_cnt = 1.
  - Each byte sees exactly one 1-cycle kbd_nextdata_n low, with 2 cycles between pop strobes.
- Typematic: 16, 16, 16, F0, 16 -> press_cnt = 1, key_ascii = 0x31, single press_pulse, key_valid = 0 at end.
- Extended: E0, 75, E0, F0, 75 -> key_code = 75, key_ext = 1, key_ascii = 0x00, press_cnt +1, then key_valid = 0. Plain 75 afterwards counts as a new press with key_ext = 0.
- Wrap: 256 distinct alternating presses (1C / 32) with CNT_W = 8 -> press_cnt returns to 0x00 and press_pulse fires 256 times.
- Reset: pull resetn low during POP after F0 -> kbd_nextdata_n = 1 immediately, outputs 0. After release, byte 1C is treated as a make, not a break.
- With KBD_SHIFT_EN: 12, 1C, F0, 1C, F0, 12, 1C -> first press ascii 0x41, second 0x61, press_cnt = 2.
